double_to_float_conv: RTL and testbench

Converts one IEEE-754 binary64 operand to binary32, rounding to nearest, ties to even. It sits between the stimulus file reader and the 32-bit result file writer in the conversion test harness. It uses the team's strobe/acknowledge handshake on both sides. It processes one operand at a time; a conversion completes before the next input is accepted.

---
 rtl/d2f_pkg.sv | 31 +++
 rtl/d2f_round.sv | 26 ++
 rtl/double_to_float_conv.sv | 208 ++++++++++++++++++++
 tb/tb_double_to_float_conv.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d2f_pkg.sv
// Shared types and constants for the binary64 -> binary32 converter.
package d2f_pkg;

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    SPECIAL,
    DENORM,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  // Exponent biases, carried in the 12-bit signed unbiased-exponent domain
  localparam logic signed [11:0] BIAS64 = 12'sd1023;
  localparam logic signed [11:0] BIAS32 = 12'sd127;

  // Unbiased exponent limits of binary32
  localparam logic signed [11:0] EXP_MAX      = 12'sd127;
  localparam logic signed [11:0] EXP_MIN_NORM = -12'sd126;
  localparam logic signed [11:0] EXP_MIN_SUB  = -12'sd151;

  // Magnitude encodings (sign bit is attached separately)
  localparam logic [30:0] INF_MAG   = 31'h7F80_0000;
  localparam logic [30:0] ZERO_MAG  = 31'h0000_0000;
  localparam logic [8:0]  QNAN_HEAD = 9'h1FF;  // all-ones exponent plus quiet bit

  // Significand with only the hidden bit set
  localparam logic [23:0] SIG_ONE = 24'h80_0000;

endpackage

// File: rtl/d2f_round.sv
// Round-to-nearest-even increment of a 24-bit significand.
// Purely combinational; carry reports overflow out of the top bit, in which
// case the significand is renormalised to 1.000... and the caller bumps e.
module d2f_round
  import d2f_pkg::*;
(
  input  logic [23:0] sig,
  input  logic        guard,
  input  logic        round,
  input  logic        sticky,
  output logic [23:0] sig_out,
  output logic        carry
);

  logic        inc;
  logic [24:0] sum;

  // Increment when above half-way, or exactly half-way with an odd LSB
  always_comb begin
    inc     = guard & (round | sticky | sig[0]);
    sum     = {1'b0, sig} + {24'd0, inc};
    carry   = sum[24];
    sig_out = sum[24] ? SIG_ONE : sum[23:0];
  end

endmodule

// File: rtl/double_to_float_conv.sv
// binary64 -> binary32 converter, round to nearest ties to even.
// Strobe/acknowledge handshake on input and output, one operand in flight.
// Build option D2F_FTZ_EN: flush every would-be subnormal result to signed
// zero and drop the DENORM shifting state.
module double_to_float_conv
  import d2f_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t             state, state_next;
  logic [63:0]        a, a_next;
  logic               s, s_next;
  logic signed [11:0] e, e_next;
  logic [51:0]        m, m_next;
  logic [23:0]        sig, sig_next;
  logic               guard_bit, guard_bit_next;
  logic               round_bit, round_bit_next;
  logic               sticky, sticky_next;
  logic [31:0]        z, z_next;
  logic               a_ack, a_ack_next;
  logic               z_stb, z_stb_next;

  logic [10:0]        exp_field;
  logic signed [11:0] e_inc;
  logic [7:0]         exp_out;
  logic [23:0]        rnd_sig;
  logic               rnd_carry;

  assign input_a_ack  = a_ack;
  assign output_z     = z;
  assign output_z_stb = z_stb;

  d2f_round u_round (
    .sig     (sig),
    .guard   (guard_bit),
    .round   (round_bit),
    .sticky  (sticky),
    .sig_out (rnd_sig),
    .carry   (rnd_carry)
  );

  // Helper values derived from the working registers
  always_comb begin
    exp_field = a[62:52];
    e_inc     = e + 12'sd1;
    exp_out   = e[7:0] + BIAS32[7:0];
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GET_A;
      a         <= '0;
      s         <= 1'b0;
      e         <= '0;
      m         <= '0;
      sig       <= '0;
      guard_bit <= 1'b0;
      round_bit <= 1'b0;
      sticky    <= 1'b0;
      z         <= '0;
      a_ack     <= 1'b0;
      z_stb     <= 1'b0;
    end else begin
      state     <= state_next;
      a         <= a_next;
      s         <= s_next;
      e         <= e_next;
      m         <= m_next;
      sig       <= sig_next;
      guard_bit <= guard_bit_next;
      round_bit <= round_bit_next;
      sticky    <= sticky_next;
      z         <= z_next;
      a_ack     <= a_ack_next;
      z_stb     <= z_stb_next;
    end
  end

  // Next-state and datapath updates for each conversion step
  always_comb begin
    state_next     = state;
    a_next         = a;
    s_next         = s;
    e_next         = e;
    m_next         = m;
    sig_next       = sig;
    guard_bit_next = guard_bit;
    round_bit_next = round_bit;
    sticky_next    = sticky;
    z_next         = z;
    a_ack_next     = a_ack;
    z_stb_next     = z_stb;

    case (state)
      GET_A: begin
        a_ack_next = 1'b1;
        if (input_a_stb && a_ack) begin
          a_next     = input_a;
          a_ack_next = 1'b0;
          state_next = UNPACK;
        end
      end

      UNPACK: begin
        s_next     = a[63];
        e_next     = $signed({1'b0, a[62:52]}) - BIAS64;
        m_next     = a[51:0];
        state_next = SPECIAL;
      end

      SPECIAL: begin
        if (exp_field == 11'h7FF && m != 52'd0) begin
          z_next     = {s, QNAN_HEAD, m[50:29]};
          z_stb_next = 1'b1;
          state_next = PUT_Z;
        end else if (exp_field == 11'h7FF) begin
          z_next     = {s, INF_MAG};
          z_stb_next = 1'b1;
          state_next = PUT_Z;
        end else if (exp_field == 11'h000) begin
          // binary64 subnormals are far below the binary32 range
          z_next     = {s, ZERO_MAG};
          z_stb_next = 1'b1;
          state_next = PUT_Z;
        end else if (e > EXP_MAX) begin
          z_next     = {s, INF_MAG};
          z_stb_next = 1'b1;
          state_next = PUT_Z;
        end else if (e < EXP_MIN_SUB) begin
          z_next     = {s, ZERO_MAG};
          z_stb_next = 1'b1;
          state_next = PUT_Z;
        end else begin
          sig_next       = {1'b1, m[51:29]};
          guard_bit_next = m[28];
          round_bit_next = m[27];
          sticky_next    = |m[26:0];
          if (e >= EXP_MIN_NORM) begin
            state_next = ROUND;
          end else begin
`ifdef D2F_FTZ_EN
            z_next     = {s, ZERO_MAG};
            z_stb_next = 1'b1;
            state_next = PUT_Z;
`else
            state_next = DENORM;
`endif
          end
        end
      end

`ifndef D2F_FTZ_EN
      DENORM: begin
        // One right shift per cycle until the exponent reaches the minimum
        sig_next       = {1'b0, sig[23:1]};
        guard_bit_next = sig[0];
        round_bit_next = guard_bit;
        sticky_next    = sticky | round_bit;
        e_next         = e_inc;
        if (e_inc == EXP_MIN_NORM) begin
          state_next = ROUND;
        end
      end
`endif

      ROUND: begin
        sig_next = rnd_sig;
        if (rnd_carry) begin
          e_next = e_inc;
        end
        state_next = PACK;
      end

      PACK: begin
        if (e > EXP_MAX) begin
          z_next = {s, INF_MAG};
        end else if (!sig[23]) begin
          z_next = {s, 8'h00, sig[22:0]};
        end else begin
          z_next = {s, exp_out, sig[22:0]};
        end
        z_stb_next = 1'b1;
        state_next = PUT_Z;
      end

      PUT_Z: begin
        if (z_stb && output_z_ack) begin
          z_stb_next = 1'b0;
          state_next = GET_A;
        end
      end

      default: begin
        state_next = GET_A;
      end
    endcase
  end

endmodule

// File: tb/tb_double_to_float_conv.sv
// Self-checking bench for double_to_float_conv: directed vectors, random
// operands against an integer-arithmetic reference, backpressure and reset.
module tb_double_to_float_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  double_to_float_conv dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  // Reference: exact value mant * 2^(e-52) quantised to the binary32 grid
  function automatic logic [31:0] ref_conv(input logic [63:0] op);
    logic        sg;
    logic [10:0] ef;
    logic [51:0] mf;
    int          ex, eq, sh;
    longint unsigned mant, n, rem, half, bits;
    sg = op[63];
    ef = op[62:52];
    mf = op[51:0];
    if (ef == 11'h7FF) begin
      if (mf != 52'd0) return {sg, 8'hFF, 1'b1, mf[50:29]};
      return {sg, 8'hFF, 23'h0};
    end
    if (ef == 11'h000) return {sg, 31'h0};
    ex = int'(ef) - 1023;
    if (ex > 127) return {sg, 8'hFF, 23'h0};
`ifdef D2F_FTZ_EN
    if (ex < -126) return {sg, 31'h0};
`endif
    if (ex < -151) return {sg, 31'h0};
    eq   = (ex < -126) ? -126 : ex;
    sh   = 29 + (eq - ex);
    mant = {11'b0, 1'b1, mf};
    n    = mant >> sh;
    rem  = mant & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && n[0])) n = n + 64'd1;
    bits = (longint'(eq + 126) << 23) + n;
    if (bits >= 64'h7F80_0000) return {sg, 8'hFF, 23'h0};
    return {sg, bits[30:0]};
  endfunction

  // Reference latency from input transfer edge to output strobe
  function automatic int ref_lat(input logic [63:0] op);
    int ex;
    if (op[62:52] == 11'h7FF || op[62:52] == 11'h000) return 2;
    ex = int'(op[62:52]) - 1023;
    if (ex > 127 || ex < -151) return 2;
    if (ex >= -126) return 4;
`ifdef D2F_FTZ_EN
    return 2;
`else
    return 4 + (-126 - ex);
`endif
  endfunction

  // Drives one operand and waits for its result; call and return at a negedge
  task automatic run_op(input logic [63:0] op, input bit do_ack,
                        output logic [31:0] res, output int lat, output bit ok);
    int w;
    ok  = 1'b1;
    lat = 0;
    res = '0;
    input_a     = op;
    input_a_stb = 1'b1;
    w = 0;
    while (!input_a_ack && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!input_a_ack) begin
      ok = 1'b0;
      input_a_stb = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    while (!output_z_stb && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!output_z_stb) begin
      ok = 1'b0;
      return;
    end
    res = output_z;
    if (do_ack) begin
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (input_a_ack !== 1'b0) begin
      n_bad++; $display("FAIL reset_ack: got %b want 0", input_a_ack);
    end
    n_cmp++;
    if (output_z_stb !== 1'b0) begin
      n_bad++; $display("FAIL reset_stb: got %b want 0", output_z_stb);
    end
    n_cmp++;
    if (output_z !== 32'h0) begin
      n_bad++; $display("FAIL reset_z: got %h want 00000000", output_z);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (input_a_ack !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ack: got %b want 1", input_a_ack);
    end
    $display("reset: ack=%b stb=%b z=%h", input_a_ack, output_z_stb, output_z);
  endtask

  task automatic test_directed();
    logic [63:0] ops [12];
    logic [31:0] exp_z [12];
    int          exp_l [12];
    logic [31:0] res;
    int          lat;
    bit          ok;
    ops[0]  = 64'h3FF0000000000000; exp_z[0]  = 32'h3F800000; exp_l[0]  = 4;
    ops[1]  = 64'hC004000000000000; exp_z[1]  = 32'hC0200000; exp_l[1]  = 4;
    ops[2]  = 64'h3FB999999999999A; exp_z[2]  = 32'h3DCCCCCD; exp_l[2]  = 4;
    ops[3]  = 64'h3FF0000010000000; exp_z[3]  = 32'h3F800000; exp_l[3]  = 4;
    ops[4]  = 64'h3FF0000030000000; exp_z[4]  = 32'h3F800002; exp_l[4]  = 4;
    ops[5]  = 64'h7FF0000000000000; exp_z[5]  = 32'h7F800000; exp_l[5]  = 2;
    ops[6]  = 64'h7FF8000000000000; exp_z[6]  = 32'h7FC00000; exp_l[6]  = 2;
    ops[7]  = 64'h7E37E43C8800759C; exp_z[7]  = 32'h7F800000; exp_l[7]  = 2;
    ops[8]  = 64'h8000000000000000; exp_z[8]  = 32'h80000000; exp_l[8]  = 2;
`ifdef D2F_FTZ_EN
    ops[9]  = 64'h36A0000000000000; exp_z[9]  = 32'h00000000; exp_l[9]  = 2;
    ops[10] = 64'h3690000000000000; exp_z[10] = 32'h00000000; exp_l[10] = 2;
    ops[11] = 64'h3690000000000001; exp_z[11] = 32'h00000000; exp_l[11] = 2;
`else
    ops[9]  = 64'h36A0000000000000; exp_z[9]  = 32'h00000001; exp_l[9]  = 27;
    ops[10] = 64'h3690000000000000; exp_z[10] = 32'h00000000; exp_l[10] = 28;
    ops[11] = 64'h3690000000000001; exp_z[11] = 32'h00000001; exp_l[11] = 28;
`endif
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], 1'b1, res, lat, ok);
      $display("directed %0d: a=%h z=%h lat=%0d", i, ops[i], res, lat);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL directed_timeout[%0d]: got no result want result", i);
      end
      n_cmp++;
      if (res !== exp_z[i]) begin
        n_bad++; $display("FAIL directed_z[%0d]: a=%h got %h want %h", i, ops[i], res, exp_z[i]);
      end
      n_cmp++;
      if (lat != exp_l[i]) begin
        n_bad++; $display("FAIL directed_lat[%0d]: got %0d want %0d", i, lat, exp_l[i]);
      end
    end
  endtask

  // Random operands, issued back to back with immediate output acknowledge
  task automatic test_random();
    logic [63:0] op;
    logic [31:0] r1, r2, res, want;
    int          sel, lat;
    int unsigned ebias;
    bit          ok;
    for (int i = 0; i < 300; i++) begin
      r1  = $urandom;
      r2  = $urandom;
      op  = {r1, r2};
      sel = int'($urandom_range(0, 9));
      if (sel == 1) begin
        op[62:52] = 11'h7FF;
      end else if (sel == 2) begin
        op[62:52] = 11'h000;
      end else if (sel >= 3) begin
        ebias = 32'd853 + $urandom_range(0, 300);
        op[62:52] = ebias[10:0];
      end
      if ($urandom_range(0, 3) == 0) op[27:0] = 28'h0;
      want = ref_conv(op);
      run_op(op, 1'b1, res, lat, ok);
      $display("random %0d: a=%h z=%h lat=%0d", i, op, res, lat);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL random_timeout[%0d]: got no result want result", i);
      end
      n_cmp++;
      if (res !== want) begin
        n_bad++; $display("FAIL random_z[%0d]: a=%h got %h want %h", i, op, res, want);
      end
      n_cmp++;
      if (lat != ref_lat(op)) begin
        n_bad++; $display("FAIL random_lat[%0d]: a=%h got %0d want %0d", i, op, lat, ref_lat(op));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int          lat;
    bit          ok;
    run_op(64'hC004000000000000, 1'b0, res, lat, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL bp_timeout: got no result want result");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (output_z_stb !== 1'b1) begin
        n_bad++; $display("FAIL bp_stb[%0d]: got %b want 1", i, output_z_stb);
      end
      n_cmp++;
      if (output_z !== 32'hC0200000) begin
        n_bad++; $display("FAIL bp_z[%0d]: got %h want c0200000", i, output_z);
      end
      n_cmp++;
      if (input_a_ack !== 1'b0) begin
        n_bad++; $display("FAIL bp_in_ack[%0d]: got %b want 0", i, input_a_ack);
      end
    end
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    n_cmp++;
    if (output_z_stb !== 1'b0) begin
      n_bad++; $display("FAIL bp_stb_drop: got %b want 0", output_z_stb);
    end
    n_cmp++;
    if (input_a_ack !== 1'b0) begin
      n_bad++; $display("FAIL bp_ack_early: got %b want 0", input_a_ack);
    end
    @(negedge clk);
    n_cmp++;
    if (input_a_ack !== 1'b1) begin
      n_bad++; $display("FAIL bp_ack_rise: got %b want 1", input_a_ack);
    end
    $display("backpressure: z=%h held 10 cycles, released", res);
  endtask

  task automatic test_reset_denorm();
    logic [31:0] res;
    int          lat, w, stb_seen, pre;
    bit          ok;
`ifdef D2F_FTZ_EN
    pre = 0;
`else
    pre = 3;
`endif
    input_a     = 64'h36A0000000000000;
    input_a_stb = 1'b1;
    w = 0;
    while (!input_a_ack && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (input_a_ack !== 1'b1) begin
      n_bad++; $display("FAIL rd_accept: got %b want 1", input_a_ack);
    end
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    repeat (pre) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (input_a_ack !== 1'b0) begin
      n_bad++; $display("FAIL rd_ack: got %b want 0", input_a_ack);
    end
    n_cmp++;
    if (output_z_stb !== 1'b0) begin
      n_bad++; $display("FAIL rd_stb: got %b want 0", output_z_stb);
    end
    stb_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (output_z_stb) stb_seen++;
    end
    n_cmp++;
    if (stb_seen != 0) begin
      n_bad++; $display("FAIL rd_no_output: got %0d strobe cycles want 0", stb_seen);
    end
    run_op(64'h3FB999999999999A, 1'b1, res, lat, ok);
    $display("reset_denorm: next a=3fb999999999999a z=%h lat=%0d", res, lat);
    n_cmp++;
    if (!ok || res !== 32'h3DCCCCCD) begin
      n_bad++; $display("FAIL rd_next_z: got %h want 3dcccccd", res);
    end
    n_cmp++;
    if (lat != 4) begin
      n_bad++; $display("FAIL rd_next_lat: got %0d want 4", lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_denorm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
